mips_cpu_alu_regs: RTL and testbench

MIPS_CPU_ALU_REGS -- requirements
Module: mips_cpu_alu_regs

---
 rtl/mips_cpu_pkg.sv | 71 +++++++
 rtl/mips_cpu_alu_core.sv | 90 +++++++++
 rtl/mips_cpu_alu_regs.sv | 74 +++++++
 tb/tb_mips_cpu_alu_regs.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pkg
//  Description : Shared MIPS opcode / function-code enumerations and widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

    localparam int c_data_w    = 32;
    localparam int c_reg_count = 32;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_BLEZ    = 6'h06,
        OP_BGTZ    = 6'h07,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LB      = 6'h20,
        OP_LH      = 6'h21,
        OP_LWL     = 6'h22,
        OP_LW      = 6'h23,
        OP_LBU     = 6'h24,
        OP_LHU     = 6'h25,
        OP_LWR     = 6'h26,
        OP_SB      = 6'h28,
        OP_SH      = 6'h29,
        OP_SW      = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        F_SLL   = 6'h00,
        F_SRL   = 6'h02,
        F_SRA   = 6'h03,
        F_SLLV  = 6'h04,
        F_SRLV  = 6'h06,
        F_SRAV  = 6'h07,
        F_JR    = 6'h08,
        F_JALR  = 6'h09,
        F_MFHI  = 6'h10,
        F_MTHI  = 6'h11,
        F_MFLO  = 6'h12,
        F_MTLO  = 6'h13,
        F_MULT  = 6'h18,
        F_MULTU = 6'h19,
        F_DIV   = 6'h1A,
        F_DIVU  = 6'h1B,
        F_ADD   = 6'h20,
        F_ADDU  = 6'h21,
        F_SUB   = 6'h22,
        F_SUBU  = 6'h23,
        F_AND   = 6'h24,
        F_OR    = 6'h25,
        F_XOR   = 6'h26,
        F_NOR   = 6'h27,
        F_SLT   = 6'h2A,
        F_SLTU  = 6'h2B
    } funct_e;

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_alu_core
//  Description : Stateless MIPS ALU: result, branch condition, carry, zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_alu_core
    import mips_cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] immediate,
    output logic [31:0] result,
    output logic        branch,
    output logic        carry_out,
    output logic        zero
);

    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic [32:0] w_addi;

    assign w_sext = {{16{immediate[15]}}, immediate};
    assign w_zext = {16'h0, immediate};
    // Bit 32 of each 33-bit sum is the carry (or borrow for the subtract)
    assign w_add  = {1'b0, a} + {1'b0, b};
    assign w_sub  = {1'b0, a} - {1'b0, b};
    assign w_addi = {1'b0, a} + {1'b0, w_sext};

    always_comb begin
        result    = '0;
        branch    = 1'b0;
        carry_out = 1'b0;
        case (opcode_e'(opcode))
            OP_SPECIAL: begin
                case (funct_e'(funct))
                    F_SLL:  result = b << shamt;
                    F_SRL:  result = b >> shamt;
                    F_SRA:  result = $unsigned($signed(b) >>> shamt);
                    F_SLLV: result = b << a[4:0];
                    F_SRLV: result = b >> a[4:0];
                    F_SRAV: result = $unsigned($signed(b) >>> a[4:0]);
                    F_ADD, F_ADDU: begin
                        result    = w_add[31:0];
                        carry_out = w_add[32];
                    end
                    F_SUB, F_SUBU: begin
                        result    = w_sub[31:0];
                        carry_out = w_sub[32];
                    end
                    F_AND:  result = a & b;
                    F_OR:   result = a | b;
                    F_XOR:  result = a ^ b;
                    F_NOR:  result = ~(a | b);
                    F_SLT:  result = {31'h0, $signed(a) < $signed(b)};
                    F_SLTU: result = {31'h0, a < b};
                    default: result = '0;
                endcase
            end
            OP_ADDIU: begin
                result    = w_addi[31:0];
                carry_out = w_addi[32];
            end
            OP_SLTI:  result = {31'h0, $signed(a) < $signed(w_sext)};
            OP_SLTIU: result = {31'h0, a < w_sext};
            OP_ANDI:  result = a & w_zext;
            OP_ORI:   result = a | w_zext;
            OP_XORI:  result = a ^ w_zext;
            OP_LUI:   result = {immediate, 16'h0};
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SW:
                result = w_addi[31:0];
            OP_BEQ:    branch = (a == b);
            OP_BNE:    branch = (a != b);
            OP_BLEZ:   branch = ($signed(a) <= 0);
            OP_BGTZ:   branch = ($signed(a) > 0);
            OP_REGIMM: branch = a[31];
            default:   result = '0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule : mips_cpu_alu_core
`default_nettype wire

// File: rtl/mips_cpu_alu_regs.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_alu_regs
//  Description : 32x32 register file (2R/1W, no bypass) feeding the MIPS ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_alu_regs
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] REG_RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  read_index_rs,
    input  logic [4:0]  read_index_rt,
    input  logic [4:0]  write_index,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic [5:0]  alu_funct,
    input  logic [5:0]  opcode,
    input  logic [4:0]  shamt,
    input  logic [15:0] immediate,
    input  logic        carry_in,
    output logic [31:0] read_data_rs,
    output logic [31:0] read_data_rt,
    output logic [31:0] register_v0,
    output logic [31:0] alu_out,
    output logic        branch,
    output logic        carry_out,
    output logic        zero
);

    logic [c_data_w-1:0] w_file [c_reg_count];
    logic                w_unused_carry_in;

    // Carry-in is reserved for future multi-word ops; no current op consumes it
    assign w_unused_carry_in = carry_in;

    // Register 0 has no storage; it is hard-wired to zero
    assign w_file[0] = '0;

    for (genvar i = 1; i < c_reg_count; i++) begin : g_regs
        logic [c_data_w-1:0] r_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_q <= REG_RESET_VALUE;
            end else if (write_enable && (write_index == 5'(i))) begin
                r_q <= write_data;
            end
        end

        assign w_file[i] = r_q;
    end

    assign read_data_rs = w_file[read_index_rs];
    assign read_data_rt = w_file[read_index_rt];
    assign register_v0  = w_file[2];

    mips_cpu_alu_core u_alu_core (
        .a         (read_data_rs),
        .b         (read_data_rt),
        .opcode    (opcode),
        .funct     (alu_funct),
        .shamt     (shamt),
        .immediate (immediate),
        .result    (alu_out),
        .branch    (branch),
        .carry_out (carry_out),
        .zero      (zero)
    );

endmodule : mips_cpu_alu_regs
`default_nettype wire

// File: tb/tb_mips_cpu_alu_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_alu_regs
//  Description : Directed bench with a behavioural register/ALU reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_alu_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  read_index_rs = '0;
    logic [4:0]  read_index_rt = '0;
    logic [4:0]  write_index = '0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [5:0]  alu_funct = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] immediate = '0;
    logic        carry_in = 1'b0;
    logic [31:0] read_data_rs;
    logic [31:0] read_data_rt;
    logic [31:0] register_v0;
    logic [31:0] alu_out;
    logic        branch;
    logic        carry_out;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    logic [31:0] m_regs [32];

    mips_cpu_alu_regs #(.REG_RESET_VALUE(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .read_index_rs (read_index_rs),
        .read_index_rt (read_index_rt),
        .write_index   (write_index),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .alu_funct     (alu_funct),
        .opcode        (opcode),
        .shamt         (shamt),
        .immediate     (immediate),
        .carry_in      (carry_in),
        .read_data_rs  (read_data_rs),
        .read_data_rt  (read_data_rt),
        .register_v0   (register_v0),
        .alu_out       (alu_out),
        .branch        (branch),
        .carry_out     (carry_out),
        .zero          (zero)
    );

    always #5 clk = ~clk;

    // Reference register store: plain memory, cleared by reset at any time
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) m_regs[k] <= 32'h0;
        end else if (write_enable && write_index != 5'd0) begin
            m_regs[write_index] <= write_data;
        end
    end

    // Returns {branch, carry, result} from the instruction-set rules
    function automatic logic [33:0] model_alu(input logic [5:0] op, input logic [5:0] fn,
                                              input logic [4:0] sh, input logic [15:0] imm,
                                              input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [31:0] se = {{16{imm[15]}}, imm};
        longint unsigned s;
        logic [31:0] r = 0;
        logic br = 0;
        logic c = 0;
        int sa = int'(a);
        int sb = int'(b);
        if (op == 6'd0) begin
            case (fn)
                6'd0:  r = b << sh;
                6'd2:  r = b >> sh;
                6'd3:  r = 32'(sb >>> sh);
                6'd4:  r = b << (a % 32);
                6'd6:  r = b >> (a % 32);
                6'd7:  r = 32'(sb >>> (a % 32));
                6'd32, 6'd33: begin s = ua + ub; r = s[31:0]; c = s[32]; end
                6'd34, 6'd35: begin s = ua - ub; r = s[31:0]; c = s[32]; end
                6'd36: r = a & b;
                6'd37: r = a | b;
                6'd38: r = a ^ b;
                6'd39: r = ~(a | b);
                6'd42: r = (sa < sb) ? 32'd1 : 32'd0;
                6'd43: r = (a < b) ? 32'd1 : 32'd0;
                default: r = 0;
            endcase
        end else begin
            case (op)
                6'd9:  begin s = ua + 64'(se); r = s[31:0]; c = s[32]; end
                6'd10: r = (sa < int'(se)) ? 32'd1 : 32'd0;
                6'd11: r = (a < se) ? 32'd1 : 32'd0;
                6'd12: r = a & {16'h0, imm};
                6'd13: r = a | {16'h0, imm};
                6'd14: r = a ^ {16'h0, imm};
                6'd15: r = {imm, 16'h0};
                6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd40, 6'd41, 6'd43:
                    r = a + se;
                6'd4:  br = (a == b);
                6'd5:  br = (a != b);
                6'd6:  br = (sa <= 0);
                6'd7:  br = (sa > 0);
                6'd1:  br = a[31];
                default: r = 0;
            endcase
        end
        return {br, c, r};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] ea, eb;
            logic [33:0] e;
            ea = m_regs[read_index_rs];
            eb = m_regs[read_index_rt];
            e  = model_alu(opcode, alu_funct, shamt, immediate, ea, eb);
            cmp("read_data_rs", read_data_rs, ea);
            cmp("read_data_rt", read_data_rt, eb);
            cmp("register_v0", register_v0, m_regs[2]);
            cmp("alu_out", alu_out, e[31:0]);
            cmp("branch", {31'h0, branch}, {31'h0, e[33]});
            cmp("carry_out", {31'h0, carry_out}, {31'h0, e[32]});
            cmp("zero", {31'h0, zero}, {31'h0, (e[31:0] == 32'h0)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        step();
        write_index  = idx;
        write_data   = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic alu(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] sh, input logic [15:0] imm);
        opcode        = op;
        alu_funct     = fn;
        read_index_rs = rs;
        read_index_rt = rt;
        shamt         = sh;
        immediate     = imm;
        @(negedge clk);
        #1;
    endtask

    logic [5:0] rfn [20] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd16, 6'd24, 6'd32,
                             6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd63};
    logic [5:0] iop [18] = '{6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                             6'd12, 6'd13, 6'd14, 6'd15, 6'd32, 6'd35, 6'd43, 6'd63};

    initial begin
        step();
        chk_en = 1'b1;

        // Write attempted while reset is held must be dropped
        write_index  = 5'd5;
        write_data   = 32'hCAFEF00D;
        write_enable = 1'b1;
        read_index_rs = 5'd5;
        @(negedge clk); #1;
        cmp("reset_rs5", read_data_rs, 32'h0);
        cmp("reset_v0", register_v0, 32'h0);
        step();
        write_enable = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        cmp("blocked_write_rs5", read_data_rs, 32'h0);

        // DEADBEEF to v0: old value before the edge, new value after
        step();
        read_index_rs = 5'd2;
        write_index   = 5'd2;
        write_data    = 32'hDEADBEEF;
        write_enable  = 1'b1;
        @(negedge clk); #1;
        cmp("pre_edge_rs2", read_data_rs, 32'h0);
        step();
        write_enable = 1'b0;
        @(negedge clk); #1;
        cmp("post_edge_v0", register_v0, 32'hDEADBEEF);

        wr(5'd0, 32'h12345678);
        read_index_rs = 5'd0;
        @(negedge clk); #1;
        cmp("r0_ignored", read_data_rs, 32'h0);

        wr(5'd10, 32'hFFFFFFFF);
        wr(5'd11, 32'h00000001);
        wr(5'd12, 32'h80000000);
        wr(5'd13, 32'h00000005);
        wr(5'd14, 32'h00000005);
        wr(5'd20, 32'h00000013);

        alu(6'd0, 6'h21, 5'd10, 5'd11, 5'd0, 16'h0);
        cmp("addu_out", alu_out, 32'h0);
        cmp("addu_zero", {31'h0, zero}, 32'd1);
        cmp("addu_carry", {31'h0, carry_out}, 32'd1);
        alu(6'd0, 6'h2A, 5'd10, 5'd11, 5'd0, 16'h0);
        cmp("slt", alu_out, 32'd1);
        alu(6'd0, 6'h2B, 5'd10, 5'd11, 5'd0, 16'h0);
        cmp("sltu", alu_out, 32'd0);

        alu(6'd0, 6'h03, 5'd0, 5'd12, 5'd4, 16'h0);
        cmp("sra", alu_out, 32'hF8000000);
        alu(6'd0, 6'h02, 5'd0, 5'd12, 5'd4, 16'h0);
        cmp("srl", alu_out, 32'h08000000);
        alu(6'h0F, 6'd0, 5'd0, 5'd0, 5'd0, 16'h1234);
        cmp("lui", alu_out, 32'h12340000);

        alu(6'h04, 6'd0, 5'd13, 5'd14, 5'd0, 16'h0);
        cmp("beq", {31'h0, branch}, 32'd1);
        alu(6'h05, 6'd0, 5'd13, 5'd14, 5'd0, 16'h0);
        cmp("bne", {31'h0, branch}, 32'd0);
        alu(6'h07, 6'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        cmp("bgtz_zero", {31'h0, branch}, 32'd0);
        alu(6'h06, 6'd0, 5'd12, 5'd0, 5'd0, 16'h0);
        cmp("blez_neg", {31'h0, branch}, 32'd1);
        alu(6'h09, 6'd0, 5'd10, 5'd0, 5'd0, 16'h0002);
        cmp("addiu", alu_out, 32'h00000001);

        // Sweep operations over a few operand pairs; the compare process checks each
        for (int p = 0; p < 3; p++) begin
            logic [4:0] ra, rb;
            ra = (p == 0) ? 5'd12 : (p == 1) ? 5'd11 : 5'd20;
            rb = (p == 0) ? 5'd10 : (p == 1) ? 5'd12 : 5'd12;
            for (int i = 0; i < 20; i++) alu(6'd0, rfn[i], ra, rb, 5'd7, 16'h8001);
            for (int i = 0; i < 18; i++) alu(iop[i], 6'd0, ra, rb, 5'd7, 16'h8001);
        end

        // Reset asserted mid-cycle during a write to r3 wins over the write
        step();
        alu_funct = 6'd0; opcode = 6'd0;
        read_index_rt = 5'd3;
        write_index   = 5'd3;
        write_data    = 32'hAAAA5555;
        write_enable  = 1'b1;
        #2;
        reset = 1'b1;
        step();
        write_enable = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk); #1;
        cmp("reset_over_write", read_data_rt, 32'h0);
        read_index_rs = 5'd2;
        @(negedge clk); #1;
        cmp("reset_clears_v0", register_v0, 32'h0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mips_cpu_alu_regs
`default_nettype wire
